// File: rtl/spectrum_averager_if.sv
// Stream and control bundle for the power-spectrum averager.
// The slave side is the averager; the master side feeds bins and collects averaged frames.
interface spectrum_averager_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  clear;
  logic [7:0]            avg_log2;
  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic                  s_axis_tvalid;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tlast;
  logic [31:0]           n_avg;

  modport master (
    output clear, avg_log2, s_axis_tdata, s_axis_tvalid,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, n_avg
  );

  modport slave (
    input  clear, avg_log2, s_axis_tdata, s_axis_tvalid,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast, n_avg
  );
endinterface

// File: rtl/spectrum_averager.sv
// Runtime-configurable power-spectrum averager.
// Accumulates 2**L frames of 2**FFT_WIDTH bins in a simple dual-port RAM and emits
// one averaged frame per period; L==0 passes samples straight through with the same latency.
module spectrum_averager #(
  parameter int FFT_WIDTH  = 12,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LOG2   = 8
) (
  input  logic               clk,
  input  logic               resetn,
  spectrum_averager_if.slave bus
);

  localparam int ACC_W = DATA_WIDTH + MAX_LOG2;
  localparam int LW    = $clog2(MAX_LOG2 + 1);
  localparam logic [FFT_WIDTH-1:0] LAST_BIN = '1;
  localparam logic [MAX_LOG2:0]    ONE_F    = 1;
  localparam logic [MAX_LOG2:0]    TWO_F    = 2;

  typedef enum logic [1:0] {ST_FIRST, ST_ACCUM, ST_LAST} state_t;

  // Requested depth clamped to the accumulator headroom.
  function automatic logic [LW-1:0] sat_log2(input logic [7:0] a);
    if (a > 8'(MAX_LOG2)) return LW'(MAX_LOG2);
    return LW'(a);
  endfunction

  // Divide by 2**l with truncation; the result always fits the output width.
  function automatic logic [DATA_WIDTH-1:0] avg_shift(input logic [ACC_W-1:0] s,
                                                      input logic [LW-1:0] l);
    logic [ACC_W-1:0] t;
    t = s >> l;
    return t[DATA_WIDTH-1:0];
  endfunction

  state_t               state;
  logic [FFT_WIDTH-1:0] bin;
  logic [MAX_LOG2-1:0]  frame;
  logic [LW-1:0]        l_reg;
  logic [31:0]          n_avg;

  logic                 accept;
  logic                 start;
  logic                 pass;
  logic [LW-1:0]        l_eff;
  logic [MAX_LOG2:0]    frame_m2;

  logic [ACC_W-1:0]     mem [2**FFT_WIDTH];

  logic                  vld_p1, vld_p2;
  logic [DATA_WIDTH-1:0] in_p1;
  logic [FFT_WIDTH-1:0]  bin_p1, bin_p2;
  logic [LW-1:0]         l_p1, l_p2;
  logic                  add_p1;
  logic                  wr_p1, wr_p2;
  logic                  out_p1, out_p2;
  logic [ACC_W-1:0]      rd_p1;
  logic [ACC_W-1:0]      sum_p2;

  logic                  out_vld;
  logic                  out_last;
  logic [DATA_WIDTH-1:0] out_data;

  // Accept qualification and the depth in force for the sample being accepted.
  always_comb begin
    accept   = bus.s_axis_tvalid && !bus.clear;
    start    = (bin == '0) && (frame == '0);
    l_eff    = start ? sat_log2(bus.avg_log2) : l_reg;
    pass     = (l_eff == '0);
    frame_m2 = (ONE_F << l_eff) - TWO_F;
  end

  // Bin/frame counters, period state and completed-frame counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_FIRST;
      bin   <= '0;
      frame <= '0;
      l_reg <= '0;
      n_avg <= '0;
    end else if (bus.clear) begin
      state <= ST_FIRST;
      bin   <= '0;
      frame <= '0;
      n_avg <= '0;
    end else begin
      if (start) l_reg <= sat_log2(bus.avg_log2);
      if (accept) begin
        bin <= bin + 1'b1;
        if (bin == LAST_BIN) begin
          if (pass) begin
            frame <= '0;
            state <= ST_FIRST;
            n_avg <= n_avg + 32'd1;
          end else begin
            case (state)
              ST_FIRST: begin
                frame <= frame + 1'b1;
                state <= (l_eff == LW'(1)) ? ST_LAST : ST_ACCUM;
              end
              ST_ACCUM: begin
                frame <= frame + 1'b1;
                state <= ({1'b0, frame} == frame_m2) ? ST_LAST : ST_ACCUM;
              end
              default: begin
                frame <= '0;
                state <= ST_FIRST;
                n_avg <= n_avg + 32'd1;
              end
            endcase
          end
        end
      end
    end
  end

  // Valid bits through the pipeline; clear flushes anything in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= accept;
      vld_p2 <= vld_p1 && !bus.clear;
    end
  end

  // ---- stage 0 -> 1: capture sample and per-sample operation, RAM read at bin ----
  always_ff @(posedge clk) begin
    in_p1  <= bus.s_axis_tdata;
    bin_p1 <= bin;
    l_p1   <= l_eff;
    add_p1 <= !pass && (state != ST_FIRST);
    wr_p1  <= !pass && (state != ST_LAST);
    out_p1 <= pass || (state == ST_LAST);
  end

  // Accumulator RAM: read latency 1, write-back from stage 2, no bypass needed.
  always_ff @(posedge clk) begin
    rd_p1 <= mem[bin];
    if (vld_p2 && wr_p2) mem[bin_p2] <= sum_p2;
  end

  // ---- stage 1 -> 2: form the full-width sum ----
  always_ff @(posedge clk) begin
    sum_p2 <= add_p1 ? (rd_p1 + ACC_W'(in_p1)) : ACC_W'(in_p1);
    bin_p2 <= bin_p1;
    l_p2   <= l_p1;
    wr_p2  <= wr_p1;
    out_p2 <= out_p1;
  end

  // ---- stage 2: output register ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      out_data <= '0;
    end else if (bus.clear) begin
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      out_data <= '0;
    end else begin
      out_vld  <= vld_p2 && out_p2;
      out_last <= vld_p2 && out_p2 && (bin_p2 == LAST_BIN);
      if (vld_p2 && out_p2) out_data <= avg_shift(sum_p2, l_p2);
    end
  end

  assign bus.m_axis_tvalid = out_vld;
  assign bus.m_axis_tlast  = out_last;
  assign bus.m_axis_tdata  = out_data;
  assign bus.n_avg         = n_avg;

endmodule
